// File: rtl/keypad_pkg.sv
// ----------------------------------------------------------------------------
// keypad_pkg
// Shared types and helpers for the keypad scanner:
//   state_t        - scan FSM states (IDLE, SCAN, EVAL)
//   key_code_t     - frame candidate encoding {none, row[2:0], col[2:0]}
//   NO_KEY         - candidate value meaning "no key pressed in this frame"
//   active_level   - pin level that means "driven row" / "pressed column"
//   inactive_level - the opposite pin level
// ----------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EVAL = 2'd2
    } state_t;

    // Bit 6 set marks "none"; a real key always has bit 6 clear, so a
    // pressed key can never compare equal to NO_KEY.
    typedef logic [6:0] key_code_t;
    localparam key_code_t NO_KEY = 7'h40;

    function automatic logic active_level(input logic active_low);
        return !active_low;
    endfunction

    function automatic logic inactive_level(input logic active_low);
        return active_low;
    endfunction

    function automatic key_code_t make_code(input logic [2:0] row, input logic [2:0] col);
        return {1'b0, row, col};
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// ----------------------------------------------------------------------------
// keypad_scan_ctrl_if
// Bundles the keypad pins, target position and event outputs of the scanner.
//   master (scanner side): in  enable, keypadCol, target_row, target_col
//                          out keypadRow, key_valid, key_row, key_col,
//                              key_held, hit, miss, state (debug)
//   slave  (user side):    the mirror image.
// Event semantics: key_valid, hit and miss are single-cycle pulses with no
// back-pressure; the consumer must take the event in the cycle it is shown.
// key_row/key_col hold the last event's position until the next event.
// ----------------------------------------------------------------------------
interface keypad_scan_ctrl_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4
);
    import keypad_pkg::*;

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    logic            enable;
    logic [COLS-1:0] keypadCol;
    logic [RW-1:0]   target_row;
    logic [CW-1:0]   target_col;
    logic [ROWS-1:0] keypadRow;
    logic            key_valid;
    logic [RW-1:0]   key_row;
    logic [CW-1:0]   key_col;
    logic            key_held;
    logic            hit;
    logic            miss;
    state_t          state;

    modport master (
        input  enable, keypadCol, target_row, target_col,
        output keypadRow, key_valid, key_row, key_col, key_held, hit, miss, state
    );

    modport slave (
        output enable, keypadCol, target_row, target_col,
        input  keypadRow, key_valid, key_row, key_col, key_held, hit, miss, state
    );

endinterface

// File: rtl/keypad_scan_tick.sv
// ----------------------------------------------------------------------------
// keypad_scan_tick
// Row dwell counter. Counts SCAN_DIV cycles per row while en_i is high and
// flags the final cycle of each dwell. Held at zero whenever en_i is low so
// every row dwell starts from a clean count.
//   clk          in  system clock
//   reset        in  asynchronous active-low reset
//   en_i         in  count enable (scanner in SCAN and enabled)
//   last_cycle_o out high on the last cycle of the current row dwell
// ----------------------------------------------------------------------------
module keypad_scan_tick #(
    parameter int SCAN_DIV = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    output logic last_cycle_o
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_cycle_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// ----------------------------------------------------------------------------
// keypad_scan_ctrl
// Keypad row scanner, frame debouncer and hit detector.
//   clk    in  system clock
//   reset  in  asynchronous active-low reset
//   kp     keypad_scan_ctrl_if.master:
//            enable      scanning enabled
//            keypadCol   raw column pins (asynchronous)
//            target_row/target_col  position compared on each event
//            keypadRow   row drive pins
//            key_valid   one-cycle press / auto-repeat event
//            key_row/key_col  position of the last event
//            key_held    a debounced key is currently down
//            hit/miss    one-cycle, event position equal / not equal target
//            state       current FSM state (debug)
// ----------------------------------------------------------------------------
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int ROWS          = 4,
    parameter int COLS          = 4,
    parameter int SCAN_DIV      = 250000,
    parameter int DEBOUNCE      = 4,
    parameter int ACTIVE_LOW    = 1,
    parameter int REPEAT_FRAMES = 0
) (
    input  logic               clk,
    input  logic               reset,
    keypad_scan_ctrl_if.master kp
);

    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(COLS);
    localparam int REP_W = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;

    localparam logic             POL_LOW  = (ACTIVE_LOW != 0);
    localparam logic             ACT      = active_level(POL_LOW);
    localparam logic             INACT    = inactive_level(POL_LOW);
    localparam logic [RW-1:0]    ROW_LAST = RW'(ROWS - 1);
    localparam logic [3:0]       DB       = 4'(DEBOUNCE);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'((REPEAT_FRAMES > 0) ? REPEAT_FRAMES - 1 : 0);

    state_t          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [COLS-1:0] col_meta_q, col_sync_q;
    key_code_t       frame_cand_q, frame_cand_d;
    key_code_t       prev_cand_q, prev_cand_d;
    key_code_t       held_code_q, held_code_d;
    logic [3:0]      stable_q, stable_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic            held_q, held_d;
    logic            key_valid_q, key_valid_d;
    logic [RW-1:0]   key_row_q, key_row_d;
    logic [CW-1:0]   key_col_q, key_col_d;

    logic            last_cycle;
    logic [COLS-1:0] pressed;
    logic [2:0]      first_col;
    logic [3:0]      stable_next;
    logic            pos_match;

    keypad_scan_tick #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .clk          (clk),
        .reset        (reset),
        .en_i         ((state_q == SCAN) && kp.enable),
        .last_cycle_o (last_cycle)
    );

    // Normalise column polarity so a 1 always means "pressed".
    assign pressed = col_sync_q ^ {COLS{INACT}};

    // Lowest pressed column wins; scanning downward leaves the lowest last.
    always_comb begin
        first_col = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (pressed[c]) begin
                first_col = 3'(c);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        frame_cand_d = frame_cand_q;
        prev_cand_d  = prev_cand_q;
        held_code_d  = held_code_q;
        stable_d     = stable_q;
        rep_d        = rep_q;
        held_d       = held_q;
        key_valid_d  = 1'b0;
        key_row_d    = key_row_q;
        key_col_d    = key_col_q;
        stable_next  = '0;

        if (!kp.enable) begin
            // Abandon any partial frame and forget all debounce history;
            // the last reported position is deliberately kept.
            state_d      = IDLE;
            row_d        = '0;
            frame_cand_d = NO_KEY;
            prev_cand_d  = NO_KEY;
            held_code_d  = NO_KEY;
            stable_d     = '0;
            rep_d        = '0;
            held_d       = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = SCAN;
                end
                SCAN: begin
                    if (last_cycle) begin
                        // Rows are visited in ascending order, so the first
                        // hit recorded in a frame is the lowest row.
                        if ((frame_cand_q == NO_KEY) && (|pressed)) begin
                            frame_cand_d = make_code(3'(row_q), first_col);
                        end
                        if (row_q == ROW_LAST) begin
                            row_d   = '0;
                            state_d = EVAL;
                        end else begin
                            row_d = row_q + RW'(1);
                        end
                    end
                end
                EVAL: begin
                    state_d      = SCAN;
                    frame_cand_d = NO_KEY;
                    prev_cand_d  = frame_cand_q;
                    if (frame_cand_q == prev_cand_q) begin
                        stable_next = (stable_q >= DB) ? DB : stable_q + 4'd1;
                    end else begin
                        stable_next = 4'd1;
                    end
                    stable_d = stable_next;

                    if (stable_next == DB) begin
                        if (frame_cand_q == NO_KEY) begin
                            held_d      = 1'b0;
                            held_code_d = NO_KEY;
                            rep_d       = '0;
                        end else if (frame_cand_q != held_code_q) begin
                            // New press, or a different key while one is held.
                            key_valid_d = 1'b1;
                            key_row_d   = RW'(frame_cand_q[5:3]);
                            key_col_d   = CW'(frame_cand_q[2:0]);
                            held_d      = 1'b1;
                            held_code_d = frame_cand_q;
                            rep_d       = '0;
                        end else if (REPEAT_FRAMES > 0) begin
                            if (rep_q == REP_LAST) begin
                                key_valid_d = 1'b1;
                                rep_d       = '0;
                            end else begin
                                rep_d = rep_q + REP_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            row_q        <= '0;
            col_meta_q   <= {COLS{INACT}};
            col_sync_q   <= {COLS{INACT}};
            frame_cand_q <= NO_KEY;
            prev_cand_q  <= NO_KEY;
            held_code_q  <= NO_KEY;
            stable_q     <= '0;
            rep_q        <= '0;
            held_q       <= 1'b0;
            key_valid_q  <= 1'b0;
            key_row_q    <= '0;
            key_col_q    <= '0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_meta_q   <= kp.keypadCol;
            col_sync_q   <= col_meta_q;
            frame_cand_q <= frame_cand_d;
            prev_cand_q  <= prev_cand_d;
            held_code_q  <= held_code_d;
            stable_q     <= stable_d;
            rep_q        <= rep_d;
            held_q       <= held_d;
            key_valid_q  <= key_valid_d;
            key_row_q    <= key_row_d;
            key_col_q    <= key_col_d;
        end
    end

    // Only the active row is driven; EVAL and IDLE leave all rows inactive.
    always_comb begin
        kp.keypadRow = {ROWS{INACT}};
        if (state_q == SCAN) begin
            kp.keypadRow[row_q] = ACT;
        end
    end

    // The target is compared in the key_valid cycle itself, so it needs to be
    // stable only while the event is presented.
    assign pos_match = (key_row_q == kp.target_row) && (key_col_q == kp.target_col);

    assign kp.key_valid = key_valid_q;
    assign kp.key_row   = key_row_q;
    assign kp.key_col   = key_col_q;
    assign kp.key_held  = held_q;
    assign kp.hit       = key_valid_q && pos_match;
    assign kp.miss      = key_valid_q && !pos_match;
    assign kp.state     = state_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
`timescale 1ns/1ps
module tb_keypad_scan_ctrl;
    import keypad_pkg::*;

    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int FRAME    = ROWS * SCAN_DIV + 1;
    localparam int REP0     = 0;
    localparam int REP1     = 2;

    // ---------------- clock / reset / shared stimulus ----------------
    logic            clk;
    logic            reset;
    logic            en;
    logic [1:0]      trow;
    logic [1:0]      tcol;
    logic [COLS-1:0] keys [ROWS];
    logic [COLS-1:0] p0, p1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    keypad_scan_ctrl_if #(.ROWS(ROWS), .COLS(COLS)) kif0 ();
    keypad_scan_ctrl_if #(.ROWS(ROWS), .COLS(COLS)) kif1 ();

    keypad_scan_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEB),
        .ACTIVE_LOW(1), .REPEAT_FRAMES(REP0)
    ) dut0 (.clk(clk), .reset(reset), .kp(kif0));

    keypad_scan_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEB),
        .ACTIVE_LOW(1), .REPEAT_FRAMES(REP1)
    ) dut1 (.clk(clk), .reset(reset), .kp(kif1));

    assign kif0.enable     = en;
    assign kif1.enable     = en;
    assign kif0.target_row = trow;
    assign kif1.target_row = trow;
    assign kif0.target_col = tcol;
    assign kif1.target_col = tcol;

    // Physical keypad: a pressed key connects its row to its column.
    always_comb begin
        p0 = '0;
        for (int r = 0; r < ROWS; r++) if (!kif0.keypadRow[r]) p0 = p0 | keys[r];
    end
    always_comb begin
        p1 = '0;
        for (int r = 0; r < ROWS; r++) if (!kif1.keypadRow[r]) p1 = p1 | keys[r];
    end
    assign kif0.keypadCol = ~p0;
    assign kif1.keypadCol = ~p1;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Frame candidates as r*4+c, -1 for none. A candidate is stable when the
    // last DEB frames all produced it.
    int         hist[$];
    bit         m_held [2];
    int         m_code [2];
    int         m_since[2];
    logic [1:0] m_row  [2];
    logic [1:0] m_col  [2];
    logic [3:0] exp_q0[$];
    logic [3:0] exp_q1[$];

    function automatic int rep_frames(input int i);
        return (i == 0) ? REP0 : REP1;
    endfunction

    task automatic push_event(input int i, input int code);
        m_row[i] = 2'(code / 4);
        m_col[i] = 2'(code % 4);
        if (i == 0) exp_q0.push_back(4'(code));
        else        exp_q1.push_back(4'(code));
    endtask

    task automatic model_disable();
        hist.delete();
        exp_q0.delete();
        exp_q1.delete();
        for (int i = 0; i < 2; i++) begin
            m_held[i]  = 1'b0;
            m_code[i]  = -1;
            m_since[i] = 0;
        end
    endtask

    task automatic model_reset();
        model_disable();
        for (int i = 0; i < 2; i++) begin
            m_row[i] = '0;
            m_col[i] = '0;
        end
    endtask

    task automatic model_frame();
        int cand;
        bit st;
        cand = -1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (cand < 0 && keys[r][c]) cand = r * 4 + c;
        hist.push_back(cand);
        if (hist.size() > 16) void'(hist.pop_front());
        st = (hist.size() >= DEB);
        for (int j = 0; j < DEB && st; j++)
            if (hist[hist.size() - 1 - j] != cand) st = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (st) begin
                if (cand < 0) begin
                    m_held[i] = 1'b0;
                    m_code[i] = -1;
                end else if (!m_held[i] || cand != m_code[i]) begin
                    push_event(i, cand);
                    m_held[i]  = 1'b1;
                    m_code[i]  = cand;
                    m_since[i] = 0;
                end else if (rep_frames(i) > 0) begin
                    m_since[i]++;
                    if (m_since[i] == rep_frames(i)) begin
                        push_event(i, cand);
                        m_since[i] = 0;
                    end
                end
            end
        end
    endtask

    // ---------------- per-cycle scoreboard ----------------
    task automatic check_outputs(input int i, input bit first);
        logic       kv, h, m, hd;
        logic [1:0] kr, kc;
        logic [3:0] ev;
        bit         exp_kv;
        bit         exp_hit;
        if (i == 0) begin
            kv = kif0.key_valid; h = kif0.hit; m = kif0.miss; hd = kif0.key_held;
            kr = kif0.key_row; kc = kif0.key_col;
        end else begin
            kv = kif1.key_valid; h = kif1.hit; m = kif1.miss; hd = kif1.key_held;
            kr = kif1.key_row; kc = kif1.key_col;
        end
        exp_kv = 1'b0;
        ev     = '0;
        if (first) begin
            if (i == 0 && exp_q0.size() > 0) begin ev = exp_q0.pop_front(); exp_kv = 1'b1; end
            if (i == 1 && exp_q1.size() > 0) begin ev = exp_q1.pop_front(); exp_kv = 1'b1; end
        end
        exp_hit = exp_kv && (ev[3:2] == trow) && (ev[1:0] == tcol);
        check_val($sformatf("key_valid%0d", i), kv, exp_kv);
        check_val($sformatf("hit%0d", i), h, exp_hit);
        check_val($sformatf("miss%0d", i), m, exp_kv && !exp_hit);
        check_val($sformatf("key_held%0d", i), hd, m_held[i]);
        check_val($sformatf("key_row%0d", i), kr, m_row[i]);
        check_val($sformatf("key_col%0d", i), kc, m_col[i]);
    endtask

    task automatic check_cycle(input int k);
        logic [ROWS-1:0] exp_rows;
        exp_rows = '1;
        if (k <= ROWS * SCAN_DIV) exp_rows[(k - 1) / SCAN_DIV] = 1'b0;
        check_val("row_drive0", kif0.keypadRow, exp_rows);
        check_val("row_drive1", kif1.keypadRow, exp_rows);
        check_outputs(0, k == 1);
        check_outputs(1, k == 1);
    endtask

    task automatic check_idle();
        check_val("idle_rows0", kif0.keypadRow, 4'hF);
        check_val("idle_rows1", kif1.keypadRow, 4'hF);
        check_outputs(0, 1'b0);
        check_outputs(1, 1'b0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_keys();
        for (int r = 0; r < ROWS; r++) keys[r] = '0;
    endtask

    task automatic press(input int r, input int c);
        keys[r][c] = 1'b1;
    endtask

    // Entered at the negedge just before a row-0 dwell begins.
    task automatic run_frame();
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            check_cycle(k);
        end
        model_frame();
    endtask

    task automatic run_frames(input int n);
        for (int f = 0; f < n; f++) run_frame();
    endtask

    task automatic run_partial(input int stop_k);
        for (int k = 1; k <= stop_k; k++) begin
            @(negedge clk);
            check_cycle(k);
        end
    endtask

    task automatic disable_idle(input int n);
        en = 1'b0;
        model_disable();
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            check_idle();
        end
        en = 1'b1;
    endtask

    task automatic reset_mid(input int n);
        reset = 1'b0;
        model_reset();
        #1;
        check_idle();
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            check_idle();
        end
        reset = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int nk, hold;
        reset = 1'b0;
        en    = 1'b0;
        trow  = '0;
        tcol  = '0;
        clear_keys();
        model_reset();
        repeat (3) @(negedge clk);
        check_idle();
        reset = 1'b1;
        @(negedge clk);
        check_idle();
        @(negedge clk);
        check_idle();
        en = 1'b1;

        // Single key on target, then release.
        trow = 2'd2; tcol = 2'd1;
        clear_keys(); press(2, 1);
        run_frames(4);
        clear_keys();
        run_frames(4);

        // Key bouncing on alternate frames never settles.
        for (int f = 0; f < 8; f++) begin
            clear_keys();
            if (f % 2 == 0) press(2, 1);
            run_frame();
        end
        clear_keys();
        run_frames(2);

        // Two keys together resolve to the lowest row.
        trow = 2'd1; tcol = 2'd3;
        press(1, 3); press(0, 2);
        run_frames(4);
        clear_keys();
        run_frames(4);

        // Long hold exercises auto-repeat on the second instance.
        trow = 2'd3; tcol = 2'd3;
        press(3, 3);
        run_frames(10);
        clear_keys();
        run_frames(4);

        // Enable dropped mid row 2 after two stable frames.
        trow = 2'd1; tcol = 2'd1;
        press(1, 1);
        run_frames(2);
        run_partial(10);
        disable_idle(3);
        run_frames(4);
        clear_keys();
        run_frames(4);

        // Randomised presses, targets, hold lengths, disables and resets.
        for (int it = 0; it < 30; it++) begin
            clear_keys();
            nk = $urandom_range(0, 2);
            for (int j = 0; j < nk; j++) press($urandom_range(0, 3), $urandom_range(0, 3));
            trow = 2'($urandom_range(0, 3));
            tcol = 2'($urandom_range(0, 3));
            hold = $urandom_range(1, 6);
            for (int f = 0; f < hold; f++) begin
                if ($urandom_range(0, 11) == 0) begin
                    run_partial($urandom_range(1, FRAME - 1));
                    if ($urandom_range(0, 1) == 1) reset_mid(2);
                    else disable_idle(2);
                end else begin
                    run_frame();
                end
            end
        end

        clear_keys();
        run_frames(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
